// File: rtl/bmu_pipe_pkg.sv
// Shared types and helpers for the pipelined bit-manipulation unit.
// Holds the one-hot operation select, the op-bit helpers and the legal XLEN set.
package bmu_pipe_pkg;

   // Number of real operation bits (modifiers unsign/csr_imm excluded)
   localparam int unsigned BMU_OP_CNT = 17;

   // Data widths the datapath supports
   localparam int unsigned BMU_XLEN_LEGAL [2] = '{32, 64};

   typedef struct packed {
      logic land;
      logic lxor;
      logic sll;
      logic sra;
      logic rol;
      logic bext;
      logic sh3add;
      logic add;
      logic slt;
      logic sub;
      logic clz;
      logic cpop;
      logic siext_h;
      logic min;
      logic packu;
      logic gorc;
      logic csr_write;
      logic unsign;
      logic csr_imm;
   } bmu_ap_t;

   // Gather only the operation bits, leaving the modifiers out
   function automatic logic [BMU_OP_CNT-1:0] bmu_op_bits(input bmu_ap_t ap);
      return {ap.land, ap.lxor, ap.sll, ap.sra, ap.rol, ap.bext, ap.sh3add,
              ap.add, ap.slt, ap.sub, ap.clz, ap.cpop, ap.siext_h, ap.min,
              ap.packu, ap.gorc, ap.csr_write};
   endfunction

   // Exactly one operation bit set
   function automatic logic bmu_op_onehot(input bmu_ap_t ap);
      return $onehot(bmu_op_bits(ap));
   endfunction

   // No operation bit set
   function automatic logic bmu_op_none(input bmu_ap_t ap);
      return (bmu_op_bits(ap) == '0);
   endfunction

endpackage

// File: rtl/bmu_pipe_alu.sv
// Combinational datapath of the bit-manipulation unit.
// Optional feature macro: BMU_PIPE_CSR_EN enables CSR read pass-through and csr_write.
module bmu_pipe_alu
   import bmu_pipe_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  bmu_ap_t         ap,
   input  logic            csr_ren,
   input  logic [XLEN-1:0] csr_rddata,
   output logic [XLEN-1:0] result,
   output logic            error
);

   localparam int unsigned SW = $clog2(XLEN);
   localparam int unsigned CW = SW + 1;

   logic [SW-1:0]     shamt;
   logic [2*XLEN-1:0] rol_wide;
   logic              lt;
   logic              clz_seen;
   logic [CW-1:0]     clz_cnt;
   logic [CW-1:0]     pop_cnt;
   logic [XLEN-1:0]   gorc_x;
   logic [XLEN-1:0]   gorc_sw;
   logic [XLEN-1:0]   op_res;
   logic              legal;

   assign shamt    = b[SW-1:0];
   assign rol_wide = {a, a} << shamt;
   assign lt       = ap.unsign ? (a < b) : ($signed(a) < $signed(b));

   // Leading-zero count (all-zero input yields XLEN) and population count
   always_comb begin
      clz_seen = 1'b0;
      clz_cnt  = '0;
      pop_cnt  = '0;
      for (int unsigned i = 0; i < XLEN; i++) begin
         if (!clz_seen) begin
            if (a[XLEN-1-i]) clz_seen = 1'b1;
            else             clz_cnt  = clz_cnt + CW'(1);
         end
         pop_cnt = pop_cnt + CW'(a[i]);
      end
   end

   // Generalised OR-combine: each enabled level ORs in a swap of adjacent 2^k-bit blocks
   always_comb begin
      gorc_x  = a;
      gorc_sw = '0;
      for (int unsigned k = 0; k < SW; k++) begin
         if (b[k]) begin
            for (int unsigned i = 0; i < XLEN; i++) begin
               gorc_sw[i] = gorc_x[i ^ (32'd1 << k)];
            end
            gorc_x = gorc_x | gorc_sw;
         end
      end
   end

   // Operation result mux; legality is resolved separately below
   always_comb begin
      op_res = '0;
      if (ap.land)         op_res = a & b;
      else if (ap.lxor)    op_res = a ^ b;
      else if (ap.sll)     op_res = a << shamt;
      else if (ap.sra)     op_res = $signed(a) >>> shamt;
      else if (ap.rol)     op_res = rol_wide[2*XLEN-1:XLEN];
      else if (ap.bext)    op_res = XLEN'(a[shamt]);
      else if (ap.sh3add)  op_res = (a << 3) + b;
      else if (ap.add)     op_res = a + b;
      else if (ap.slt)     op_res = XLEN'(lt);
      else if (ap.sub)     op_res = a - b;
      else if (ap.clz)     op_res = XLEN'(clz_cnt);
      else if (ap.cpop)    op_res = XLEN'(pop_cnt);
      else if (ap.siext_h) op_res = {{(XLEN-16){a[15]}}, a[15:0]};
      else if (ap.min)     op_res = lt ? a : b;
      else if (ap.packu)   op_res = {b[XLEN-1:XLEN/2], a[XLEN-1:XLEN/2]};
      else if (ap.gorc)    op_res = gorc_x;
`ifdef BMU_PIPE_CSR_EN
      else if (ap.csr_write) op_res = ap.csr_imm ? b : a;
`endif
   end

`ifdef BMU_PIPE_CSR_EN
   // CSR read is the only legal case with no op bit; it may not combine with an op
   always_comb begin
      if (bmu_op_none(ap)) begin
         legal  = csr_ren;
         result = csr_ren ? csr_rddata : '0;
      end else begin
         legal  = bmu_op_onehot(ap) && !csr_ren;
         result = legal ? op_res : '0;
      end
   end
`else
   logic unused_csr;
   assign unused_csr = ^{csr_rddata, ap.csr_imm};

   // Without CSR support any CSR request or csr_write is illegal
   always_comb begin
      legal  = bmu_op_onehot(ap) && !ap.csr_write && !csr_ren;
      result = legal ? op_res : '0;
   end
`endif

   assign error = !legal;

endmodule

// File: rtl/bmu_pipe.sv
// Pipelined bit-manipulation unit: handshake, stage registers and error counter.
// Optional feature macro: BMU_PIPE_CSR_EN (CSR read pass-through and csr_write).
module bmu_pipe
   import bmu_pipe_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned STAGES    = 2,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   output logic                 in_ready,
   input  logic [XLEN-1:0]      a_in,
   input  logic [XLEN-1:0]      b_in,
   input  bmu_ap_t              ap,
   input  logic                 csr_ren_in,
   input  logic [XLEN-1:0]      csr_rddata_in,
   input  logic                 scan_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      result_ff,
   output logic                 error,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   if (!((XLEN == BMU_XLEN_LEGAL[0]) || (XLEN == BMU_XLEN_LEGAL[1]))) begin : g_bad_xlen
      $error("bmu_pipe: XLEN must be 32 or 64");
   end
   if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
      $error("bmu_pipe: STAGES must be 1..4");
   end

   logic [XLEN-1:0]   alu_result;
   logic              alu_error;
   logic              accept;
   logic              succ_take;
   logic [STAGES-1:0] stg_valid;
   logic [STAGES-1:0] stg_load;
   logic [STAGES-1:0] stg_error;
   logic [XLEN-1:0]   stg_result [STAGES];

   bmu_pipe_alu #(
      .XLEN (XLEN)
   ) u_alu (
      .a          (a_in),
      .b          (b_in),
      .ap         (ap),
      .csr_ren    (csr_ren_in),
      .csr_rddata (csr_rddata_in),
      .result     (alu_result),
      .error      (alu_error)
   );

   // A stage loads when empty or when its successor takes its content; walk back from the output
   always_comb begin
      succ_take = out_ready;
      stg_load  = '0;
      for (int unsigned j = 0; j < STAGES; j++) begin
         stg_load[STAGES-1-j] = !stg_valid[STAGES-1-j] || succ_take;
         succ_take            = stg_load[STAGES-1-j];
      end
   end

   assign in_ready = !rst && !scan_mode && stg_load[0];
   assign accept   = valid_in && in_ready;

   // Stage registers and saturating count of delivered errored results
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_valid <= '0;
         stg_error <= '0;
         for (int unsigned i = 0; i < STAGES; i++) stg_result[i] <= '0;
         err_cnt   <= '0;
      end else begin
         if (stg_load[0]) begin
            stg_valid[0] <= accept;
            if (accept) begin
               stg_result[0] <= alu_result;
               stg_error[0]  <= alu_error;
            end
         end
         for (int unsigned i = 1; i < STAGES; i++) begin
            if (stg_load[i]) begin
               stg_valid[i] <= stg_valid[i-1];
               if (stg_valid[i-1]) begin
                  stg_result[i] <= stg_result[i-1];
                  stg_error[i]  <= stg_error[i-1];
               end
            end
         end
         if (out_valid && out_ready && error && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end
   end

   assign out_valid = stg_valid[STAGES-1];
   assign result_ff = stg_result[STAGES-1];
   assign error     = stg_error[STAGES-1];

endmodule

// File: doc/bmu_pipe.md
# bmu_pipe

Parametrised, pipelined successor to the single-cycle bit-manipulation unit. It executes the same one-hot operation set over a configurable data width XLEN with a configurable number of register stages. A valid/ready handshake on both sides provides backpressure and bubble collapsing. It also keeps a saturating count of errored operations, and sits between the decode/issue stage and writeback.

## Interface
- XLEN, 32, data width; legal values 32 or 64.
- STAGES, 2, pipeline depth in register stages; legal values 1..4.
- ERR_CNT_W, 8, width of the error counter.
- clk  in  1  clock.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- valid_in  in  1  operation offered.
- in_ready  out  1  operation accepted when valid_in && in_ready.
- a_in, b_in  in  XLEN each  operands (signed).
- ap  in  bmu_ap_t  one-hot operation select.
- csr_ren_in  in  1  CSR read pass-through request.
- csr_rddata_in  in  XLEN  CSR read data.
- scan_mode  in  1  blocks acceptance while high.
- out_valid  out  1  result_ff/error valid.
- out_ready  in  1  consumer takes result when out_valid && out_ready.
- result_ff  out  XLEN  result.
- error  out  1  result belongs to an illegal operation.
- err_cnt  out  ERR_CNT_W  saturating count of errored results delivered.

## Operation
- shamt = b_in[$clog2(XLEN)-1:0]. Arithmetic wraps modulo 2^XLEN; overflow is never an error.
- land a&b; lxor a^b; sll a<<shamt; sra arithmetic right shift; rol rotate-left; bext (a>>shamt)&1.
- add a+b; sub a-b; sh3add (a<<3)+b.
- slt: 1/0 compare; min: smaller operand. Both are signed, or unsigned when ap.unsign=1.
- clz: leading zeros, and clz(0)=XLEN. cpop: count of ones, 0..XLEN.
- siext_h: sign-extends a[15:0]. packu: {b[XLEN-1:XLEN/2], a[XLEN-1:XLEN/2]}.
- gorc: for k in 0..log2(XLEN)-1, if b[k] then x |= swap of adjacent 2^k-bit blocks.
- csr_write: result = csr_imm ? b_in : a_in.
- CSR read: csr_ren_in=1 with no op bit set gives result = csr_rddata_in.
- Error cases, each giving error=1 and result 0:
  - more than one op bit set;
  - no op bit set and csr_ren_in=0;
  - csr_ren_in=1 together with any op bit.
- unsign and csr_imm are modifiers and do not count as op bits.
- err_cnt increments on each delivered errored result (out_valid && out_ready && error) and saturates at all-ones.

## Timing
- The result is computed combinationally from the inputs and captured into stage 1. Stages 2..STAGES are delay registers.
- The output is stage STAGES. Latency from acceptance to out_valid is exactly STAGES cycles when there is no backpressure.
- A stage loads when it is empty or its successor advances. Bubbles collapse.
- in_ready = !rst && !scan_mode && (stage 1 empty or stage 1 advancing).
- Throughput is 1/cycle while out_ready=1.
- out_valid && !out_ready holds result_ff/error stable until taken. The pipeline then fills to STAGES entries, after which in_ready=0.
- Simultaneous take and accept on a full pipeline: all stages shift and the new operation enters stage 1, with no loss.
- Ordering is strictly FIFO.
- Reset and reset mid-operation: all stage valids are cleared and in-flight operations are discarded.
- Reset values: out_valid=0, result_ff=0, error=0, err_cnt=0, in_ready=0 while rst is high. in_ready=1 the first cycle after rst falls, if scan_mode=0.
- scan_mode rising mid-flight: no new acceptance; in-flight operations drain normally.

## Configuration
- BMU_PIPE_CSR_EN defined: the CSR read pass-through and the csr_write operation behave as above.
- BMU_PIPE_CSR_EN undefined: the ports remain but csr_rddata_in is ignored. csr_write, or csr_ren_in=1, is treated as illegal (error=1, result 0, counted).

## Structure
- Package bmu_pipe_pkg:
  - bmu_ap_t packed one-hot struct: land, lxor, sll, sra, rol, bext, sh3add, add, slt, sub, clz, cpop, siext_h, min, packu, gorc, csr_write, plus modifiers unsign and csr_imm;
  - function checking the op bits for one-hot;
  - constant for the legal XLEN set.
- Sub-module bmu_pipe_alu: the purely combinational datapath. The top level owns the handshake, stage registers and counter.

## Test plan
- XLEN=32, STAGES=2, add a=0x7FFFFFFF b=1, out_ready=1 -> out_valid exactly 2 cycles after acceptance, result 0x80000000, error 0.
- clz a=0 -> 32. cpop a=0xF0F00001 -> 9. siext_h a=0x00008001 -> 0xFFFF8001. gorc a=0x01000000 b=7 -> 0xFF000000.
- Three back-to-back operations with out_ready=0 -> two held, in_ready=0 on the third. Raise out_ready -> all three delivered in order with no duplicates.
- ap with land+lxor set -> error=1, result 0, err_cnt 0->1. With ERR_CNT_W=2, five errors -> err_cnt stays 3.
- rst asserted with two operations in flight -> the next cycle has out_valid=0 and err_cnt=0, and no stale result is delivered after release.
- XLEN=64, sll a=1 b=63 -> 0x8000000000000000. Without BMU_PIPE_CSR_EN, csr_ren_in=1 -> error=1.
